// File: rtl/of_action_dispatcher.sv
// rtl/of_action_dispatcher.sv - flow-table lookup result to action-word dispatcher with consumer credit tracking
// Optional feature macro: OF_ACTION_MISS_TO_CPU_EN (table misses forward to the CPU port instead of dropping)

`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 64
`endif
`ifndef OF_ACTION_CTRL_WIDTH
`define OF_ACTION_CTRL_WIDTH 8
`endif
`ifndef OF_IN_PORT
`define OF_IN_PORT 16
`endif
`ifndef OF_IN_PORT_POS
`define OF_IN_PORT_POS 0
`endif

module of_action_dispatcher #(
  parameter int unsigned OF_ACTION_DATA_WIDTH = `OF_ACTION_DATA_WIDTH,
  parameter int unsigned OF_ACTION_CTRL_WIDTH = `OF_ACTION_CTRL_WIDTH,
  parameter int unsigned ENTRY_ADDR_WIDTH     = 5,
  parameter int unsigned CREDITS              = 4,
  parameter logic [15:0] CPU_PORT_MASK        = 16'h0002
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            lookup_req,
  input  logic                            lookup_hit,
  input  logic [ENTRY_ADDR_WIDTH-1:0]     lookup_entry,
  output logic                            lookup_rdy,
  output logic                            act_rd_en,
  output logic [ENTRY_ADDR_WIDTH-1:0]     act_rd_addr,
  input  logic [OF_ACTION_DATA_WIDTH-1:0] act_rd_data,
  output logic [OF_ACTION_DATA_WIDTH-1:0] action_data_bus,
  output logic [OF_ACTION_CTRL_WIDTH-1:0] action_ctrl_bus,
  output logic                            action_valid,
  input  logic                            action_rd,
  output logic [31:0]                     hit_count,
  output logic [31:0]                     miss_count
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  // Ctrl encoding: bit 0 = hit, bit 1 = drop, upper bits always zero
  localparam logic [OF_ACTION_CTRL_WIDTH-1:0] HIT_CTRL = OF_ACTION_CTRL_WIDTH'(2'b01);

`ifdef OF_ACTION_MISS_TO_CPU_EN
  // Miss forwards the packet to the CPU port; only the output-port field is populated
  localparam logic [OF_ACTION_DATA_WIDTH-1:0] MISS_DATA =
    OF_ACTION_DATA_WIDTH'(CPU_PORT_MASK[`OF_IN_PORT-1:0]) << `OF_IN_PORT_POS;
  localparam logic [OF_ACTION_CTRL_WIDTH-1:0] MISS_CTRL = OF_ACTION_CTRL_WIDTH'(2'b00);
`else
  // Miss drops the packet; the action word carries no forwarding information
  localparam logic [OF_ACTION_DATA_WIDTH-1:0] MISS_DATA = '0;
  localparam logic [OF_ACTION_CTRL_WIDTH-1:0] MISS_CTRL = OF_ACTION_CTRL_WIDTH'(2'b10);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_ISSUE
  } state_t;

  state_t                          state_q;
  logic                            lookup_rdy_q;
  logic                            act_rd_en_q;
  logic [ENTRY_ADDR_WIDTH-1:0]     act_rd_addr_q;
  logic [OF_ACTION_DATA_WIDTH-1:0] pend_data_q;
  logic [OF_ACTION_CTRL_WIDTH-1:0] pend_ctrl_q;
  logic                            action_valid_q;
  logic [OF_ACTION_DATA_WIDTH-1:0] action_data_q;
  logic [OF_ACTION_CTRL_WIDTH-1:0] action_ctrl_q;

  logic [CW-1:0]                   credit_q;
  logic [CW-1:0]                   credit_d;
  logic [31:0]                     hit_count_q;
  logic [31:0]                     hit_count_d;
  logic [31:0]                     miss_count_q;
  logic [31:0]                     miss_count_d;

  logic                            accept;
  logic                            issue;

  assign accept = lookup_req && lookup_rdy_q;
  // A strobe on the bus is the moment a credit is consumed
  assign issue  = action_valid_q;

  // Credit bookkeeping: pop returns a credit, issue consumes one, both together cancel
  always_comb begin
    credit_d = credit_q;
    if (action_rd && !issue) begin
      if (credit_q != CREDIT_MAX) begin
        credit_d = credit_q + 1'b1;
      end
    end else if (!action_rd && issue) begin
      credit_d = credit_q - 1'b1;
    end
  end

  // Statistics count accepted lookups only and wrap naturally at 32 bits
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (accept && lookup_hit) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (accept && !lookup_hit) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  // Credit and statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q     <= CREDIT_MAX;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      credit_q     <= credit_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Dispatcher FSM; the strobe is raised on the edge that enters ISSUE whenever the
  // post-edge credit count is non-zero, so it lands in the first ISSUE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      lookup_rdy_q   <= 1'b0;
      act_rd_en_q    <= 1'b0;
      act_rd_addr_q  <= '0;
      pend_data_q    <= '0;
      pend_ctrl_q    <= '0;
      action_valid_q <= 1'b0;
      action_data_q  <= '0;
      action_ctrl_q  <= '0;
    end else begin
      act_rd_en_q    <= 1'b0;
      action_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          lookup_rdy_q <= 1'b1;
          if (accept) begin
            lookup_rdy_q <= 1'b0;
            if (lookup_hit) begin
              act_rd_en_q   <= 1'b1;
              act_rd_addr_q <= lookup_entry;
              state_q       <= S_READ;
            end else begin
              pend_data_q <= MISS_DATA;
              pend_ctrl_q <= MISS_CTRL;
              state_q     <= S_ISSUE;
              if (credit_d != '0) begin
                action_valid_q <= 1'b1;
                action_data_q  <= MISS_DATA;
                action_ctrl_q  <= MISS_CTRL;
              end
            end
          end
        end
        S_READ: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          pend_data_q <= act_rd_data;
          pend_ctrl_q <= HIT_CTRL;
          state_q     <= S_ISSUE;
          if (credit_d != '0) begin
            action_valid_q <= 1'b1;
            action_data_q  <= act_rd_data;
            action_ctrl_q  <= HIT_CTRL;
          end
        end
        S_ISSUE: begin
          if (action_valid_q) begin
            state_q      <= S_IDLE;
            lookup_rdy_q <= 1'b1;
          end else if (credit_d != '0) begin
            action_valid_q <= 1'b1;
            action_data_q  <= pend_data_q;
            action_ctrl_q  <= pend_ctrl_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign lookup_rdy      = lookup_rdy_q;
  assign act_rd_en       = act_rd_en_q;
  assign act_rd_addr     = act_rd_addr_q;
  assign action_valid    = action_valid_q;
  assign action_data_bus = action_data_q;
  assign action_ctrl_bus = action_ctrl_q;
  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;

endmodule
